// File: rtl/anb_smc_rd_arb.sv
// N-client round-robin read arbiter between ANB read masters and the SMC read port.
// Optional protocol checker (err output) enabled by defining ANB_SMC_RD_ARB_CHECK_EN.
module anb_smc_rd_arb #(
    parameter int unsigned N       = 4,
    parameter int unsigned AW      = 32,
    parameter int unsigned LW      = 16,
    parameter int unsigned DW      = 64,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N*AW-1:0]       c_addr,
    input  logic [N*LW-1:0]       c_len,
    input  logic [N-1:0]          c_avalid,
    output logic [N-1:0]          c_aready,
    output logic [DW-1:0]         c_data,
    output logic                  c_last,
    output logic [N-1:0]          c_valid,
    input  logic [N-1:0]          c_ready,
    output logic [$clog2(N)-1:0]  m_aid,
    output logic [AW-1:0]         m_addr,
    output logic [LW-1:0]         m_len,
    output logic                  m_avalid,
    input  logic                  m_aready,
    input  logic [$clog2(N)-1:0]  m_id,
    input  logic [DW-1:0]         m_data,
    input  logic [DW/8-1:0]       m_strb,
    input  logic                  m_valid,
    output logic                  m_ready,
    input  logic                  m_last
`ifdef ANB_SMC_RD_ARB_CHECK_EN
    ,
    output logic                  err
`endif
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = $clog2(MAX_OUT + 1);

    typedef enum logic {StIdle, StIssue} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [IW-1:0]   gnt_idx, cand;
    logic            gnt_found, capture, grant;
    logic [N-1:0]    eligible;
    logic [CW-1:0]   out_cnt_q [N];
    logic [N-1:0]    cnt_inc, cnt_dec;

    logic [IW-1:0]   fid_q   [2];
    logic [DW-1:0]   fdata_q [2];
    logic [1:0]      flast_q;
    logic            rd_ptr_q, wr_ptr_q;
    logic [1:0]      fcnt_q, fcnt_d;
    logic [IW-1:0]   head_id;
    logic            fifo_nonempty, pop, push, accept, id_ok;

    logic unused_strb;
    assign unused_strb = ^m_strb;

    // ---------------- address arbitration ----------------
    always_comb begin
        for (int k = 0; k < N; k++) begin
            eligible[k] = c_avalid[k] && (out_cnt_q[k] < CW'(MAX_OUT));
        end
    end

    // First eligible client at or after the RR pointer, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = rr_q;
        for (int i = 0; i < N; i++) begin
            if (!gnt_found && eligible[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
            cand = (cand == IW'(N - 1)) ? '0 : cand + 1'b1;
        end
    end

    assign capture  = (state_q == StIdle) || m_aready;
    assign grant    = capture && gnt_found && !rst;
    assign c_aready = grant ? (N'(1) << gnt_idx) : '0;
    assign m_avalid = (state_q == StIssue);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        if (capture) begin
            if (grant) begin
                state_d = StIssue;
                rr_d    = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            rr_q    <= '0;
            m_aid   <= '0;
            m_addr  <= '0;
            m_len   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            if (grant) begin
                m_aid  <= gnt_idx;
                m_addr <= c_addr[int'(gnt_idx)*AW +: AW];
                m_len  <= c_len[int'(gnt_idx)*LW +: LW];
            end
        end
    end

    // ---------------- outstanding counters ----------------
    always_comb begin
        for (int k = 0; k < N; k++) begin
            cnt_inc[k] = grant && (gnt_idx == IW'(k));
            cnt_dec[k] = pop && c_last && (head_id == IW'(k)) && (out_cnt_q[k] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) out_cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (cnt_inc[k] && !cnt_dec[k]) begin
                    out_cnt_q[k] <= out_cnt_q[k] + 1'b1;
                end else if (cnt_dec[k] && !cnt_inc[k]) begin
                    out_cnt_q[k] <= out_cnt_q[k] - 1'b1;
                end
            end
        end
    end

    // ---------------- return data skid buffer ----------------
    generate
        if ((2 ** IW) == N) begin : g_id_full
            assign id_ok = 1'b1;
        end else begin : g_id_part
            assign id_ok = ({1'b0, m_id} < (IW + 1)'(N));
        end
    endgenerate

    assign head_id       = fid_q[rd_ptr_q];
    assign fifo_nonempty = (fcnt_q != 2'd0);
    assign c_valid       = fifo_nonempty ? (N'(1) << head_id) : '0;
    assign c_data        = fdata_q[rd_ptr_q];
    assign c_last        = flast_q[rd_ptr_q];
    assign pop           = fifo_nonempty && c_ready[head_id];
    assign accept        = m_valid && m_ready;
    assign push          = accept && id_ok;

    always_comb begin
        fcnt_d = fcnt_q;
        if (push && !pop) begin
            fcnt_d = fcnt_q + 2'd1;
        end else if (pop && !push) begin
            fcnt_d = fcnt_q - 2'd1;
        end
    end

    // Ready is registered, so only advertise it when a slot is guaranteed next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt_q   <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            m_ready  <= 1'b0;
            flast_q  <= '0;
            for (int e = 0; e < 2; e++) begin
                fid_q[e]   <= '0;
                fdata_q[e] <= '0;
            end
        end else begin
            fcnt_q  <= fcnt_d;
            m_ready <= (fcnt_d != 2'd2);
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            if (push) begin
                fid_q[wr_ptr_q]   <= m_id;
                fdata_q[wr_ptr_q] <= m_data;
                flast_q[wr_ptr_q] <= m_last;
                wr_ptr_q          <= ~wr_ptr_q;
            end
        end
    end

`ifdef ANB_SMC_RD_ARB_CHECK_EN
    logic bad_beat;

    always_comb begin
        bad_beat = 1'b0;
        if (accept) begin
            if (!id_ok) begin
                bad_beat = 1'b1;
            end else if (m_last && (out_cnt_q[m_id] == '0)) begin
                bad_beat = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (bad_beat) begin
            err <= 1'b1;
        end
    end
`endif

endmodule
